hazard_control_unit: RTL
========================

# hazard_control_unit

Pipeline hazard and stall controller for the five-stage pipeline. It handles the hazards that operand forwarding cannot resolve: load-use dependencies, instruction and data memory wait states, taken-branch/jump squashes, and halt. It drives the per-latch enable and flush signals for IF/ID, ID/EX, EX/MEM and MEM/WB, plus the PC enable, and keeps saturating performance counters for stall and flush cycles.

## Interface

- `CNT_W`, default 16: width of each performance counter.
- `CLK` in 1: clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `ihit` in 1: instruction memory returned a valid word this cycle.
- `dhit` in 1: data memory completed the request this cycle.
- `dREN_mem`, `dWEN_mem` in 1: a load or store is in the MEM stage.
- `memRead_ex` in 1: the instruction in EX is a load.
- `Rd_ex` in 5: destination register of the EX instruction.
- `Rs_dec`, `Rt_dec` in 5: source registers of the decode instruction.
- `useRt_dec` in 1: the decode instruction reads Rt.
- `pcsrc_mem` in 1: a taken branch or jump is resolved in MEM.
- `halt_mem` in 1: HALT is in the MEM stage.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1: latch enables.
- `ifid_flush`, `idex_flush`, `exmem_flush` out 1: load a bubble on this edge.
- `halted` out 1: the core has halted.
- `stall_cnt`, `flush_cnt` out CNT_W: performance counters.

## Operation

- FSM states: RUN, DWAIT, HALTED. Enable and flush outputs are combinational from state and inputs. State and counters are registered.
- **RUN.** Conditions are evaluated in priority order; the first match wins:
  1. `halt_mem` and no `dREN_mem`/`dWEN_mem` pending: all enables 0, `memwb_en`=1 (HALT retires). Next state is HALTED.
  2. (`dREN_mem`|`dWEN_mem`) and `!dhit`: all enables 0, no flushes. Next state is DWAIT.
  3. `pcsrc_mem`: all enables 1, `ifid_flush`=`idex_flush`=`exmem_flush`=1. The PC loads the target.
  4. Load-use, defined as `memRead_ex` and `Rd_ex`≠0 and (`Rd_ex`==`Rs_dec` or (`useRt_dec` and `Rd_ex`==`Rt_dec`)): `pc_en`=`ifid_en`=0, `idex_flush`=1, later stages enabled.
  5. `!ihit`: `pc_en`=0, `ifid_flush`=1, all other enables 1 (the back end drains).
  6. Otherwise all enables 1 and no flushes.
- **DWAIT.** While `!dhit`, all enables are 0. On `dhit`, outputs are evaluated as in RUN with rule 2 suppressed, and the next state is RUN. Rules 3–5 therefore apply in the completion cycle.
- **HALTED.** All enables and flushes are 0 and `halted`=1. Only `RST` exits this state.
- `stall_cnt` increments in every cycle where `pc_en`=0 and the state is not HALTED.
- `flush_cnt` increments in every cycle where any flush output is 1.
- Both counters saturate at 2^CNT_W−1 and never wrap.
- `Rd_ex`=0 never triggers load-use.
- An `Rt` match with `useRt_dec`=0 is ignored.

## Timing

- Reset: on a `RST`-high edge, state becomes RUN, `stall_cnt`=`flush_cnt`=0 and `halted`=0. While `RST` is high, all enables are 0 and all flushes are 0. `RST` overrides every other input on the same edge, including from HALTED or DWAIT.
- Latency: enables and flushes are valid in the same cycle as their inputs. State changes and counter updates take effect on the next rising edge.
- A load-use stall lasts exactly one cycle. The next cycle sees a bubble in EX, so the load has moved to MEM and forwarding covers it.
- A branch flush in the same cycle as a load-use hazard: the flush wins, and no stall is counted.
- `dhit` in the same cycle a request first appears: no DWAIT entry and zero stall cycles.
- `halted` asserts on the cycle after HALT retires and stays high.

## Structure

- The shared package `cpu_types_pkg` holds `regbits_t` (5-bit register index) and an enum `hazard_state_t` {RUN, DWAIT, HALTED}.
- One sub-module is natural: `sat_counter` (parameter `W`; inputs `CLK`, `RST`, `inc`; output `count`), instantiated twice.
- An interface file `hazard_control_unit_if.vh` groups the ports, with modports `hcu` and `tb`.

## Test plan

- `memRead_ex`=1, `Rd_ex`=8, `Rs_dec`=8 → one cycle of `pc_en`=`ifid_en`=0 with `idex_flush`=1; `stall_cnt` goes 0→1.
- `dREN_mem`=1 with `dhit` low for 3 cycles then high → 3 cycles with all enables 0, then all enables 1 on the `dhit` cycle; `stall_cnt`=3 and the state returns to RUN.
- `pcsrc_mem`=1 together with a load-use match (`Rd_ex`=`Rt_dec`=5, `useRt_dec`=1) → three flushes, `pc_en`=1, `flush_cnt`+1, `stall_cnt` unchanged.
- `halt_mem`=1 with the memory idle → `memwb_en`=1 only. Next cycle `halted`=1 with all enables 0 for 10 cycles; `RST` pulse → `halted`=0 and counters 0.
- `CNT_W`=4, hold `ihit`=0 for 20 cycles → `stall_cnt` saturates at 15; `ifid_flush`=1 every cycle and `flush_cnt`=15.
- `RST` asserted mid-DWAIT with `dhit` low → next cycle the state is RUN and all outputs are at their reset values.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index and hazard controller FSM state.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Port bundle for the hazard controller; hcu is the controller view, tb drives stimulus.
interface hazard_control_unit_if #(
  parameter int unsigned CNT_W = 16
) (
  input logic CLK
);
  import cpu_types_pkg::*;

  logic             RST;
  logic             ihit;
  logic             dhit;
  logic             dREN_mem;
  logic             dWEN_mem;
  logic             memRead_ex;
  regbits_t         Rd_ex;
  regbits_t         Rs_dec;
  regbits_t         Rt_dec;
  logic             useRt_dec;
  logic             pcsrc_mem;
  logic             halt_mem;
  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             memwb_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport hcu (
    input  CLK, RST, ihit, dhit, dREN_mem, dWEN_mem, memRead_ex, Rd_ex, Rs_dec, Rt_dec,
           useRt_dec, pcsrc_mem, halt_mem,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           exmem_flush, halted, stall_cnt, flush_cnt
  );

  modport tb (
    input  CLK, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           exmem_flush, halted, stall_cnt, flush_cnt,
    output RST, ihit, dhit, dREN_mem, dWEN_mem, memRead_ex, Rd_ex, Rs_dec, Rt_dec,
           useRt_dec, pcsrc_mem, halt_mem
  );

endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Advance on inc unless already at the all-ones ceiling.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard/stall controller: latch enables, bubble injection, halt and perf counters.
module hazard_control_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dREN_mem,
  input  logic             dWEN_mem,
  input  logic             memRead_ex,
  input  regbits_t         Rd_ex,
  input  regbits_t         Rs_dec,
  input  regbits_t         Rt_dec,
  input  logic             useRt_dec,
  input  logic             pcsrc_mem,
  input  logic             halt_mem,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hazard_state_t state_q;
  hazard_state_t state_d;
  logic          halted_q;
  logic          mem_req;
  logic          load_use;
  logic          evaluate;
  logic          stall_inc;
  logic          flush_inc;

  assign mem_req  = dREN_mem | dWEN_mem;
  assign load_use = memRead_ex && (Rd_ex != '0) &&
                    ((Rd_ex == Rs_dec) || (useRt_dec && (Rd_ex == Rt_dec)));

  // Priority decode of enables/flushes. The DWAIT completion cycle shares the RUN
  // rules with the memory-wait rule masked, since the pending access has just finished.
  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    evaluate    = (state_q == RUN) || ((state_q == DWAIT) && dhit);

    if (!RST && evaluate) begin
      if (state_q == DWAIT) begin
        state_d = RUN;
      end
      if (halt_mem && !mem_req) begin
        memwb_en = 1'b1;
        state_d  = HALTED;
      end else if ((state_q == RUN) && mem_req && !dhit) begin
        state_d = DWAIT;
      end else if (pcsrc_mem) begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (load_use) begin
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        idex_flush = 1'b1;
      end else if (!ihit) begin
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        memwb_en = 1'b1;
      end
    end
  end

  // FSM state and registered halted flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= RUN;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == HALTED);
    end
  end

  assign halted = halted_q;

  // Counter increment qualifiers.
  always_comb begin
    stall_inc = !pc_en && (state_q != HALTED);
    flush_inc = ifid_flush | idex_flush | exmem_flush;
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule
